// File: rtl/ufm_ext_responder.sv
// Responder for the register block's flash external interface. Turns held-level read/write
// requests into Avalon-MM accesses on the UFM data and CSR ports and returns a one-cycle ack.
module ufm_ext_responder #(
  parameter int unsigned          DATA_AW        = 17,
  parameter int unsigned          TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = '1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [23:0]        ext_address,
  input  logic               ext_read,
  input  logic               ext_write,
  input  logic [31:0]        ext_write_data,
  input  logic [3:0]         ext_byte_enable,
  output logic [31:0]        ext_read_data,
  output logic               ext_acknowledge,
  output logic [DATA_AW-1:0] avmm_data_addr,
  output logic               avmm_data_read,
  output logic               avmm_data_write,
  output logic [31:0]        avmm_data_writedata,
  input  logic [31:0]        avmm_data_readdata,
  input  logic               avmm_data_waitrequest,
  input  logic               avmm_data_readdatavalid,
  output logic               avmm_csr_addr,
  output logic               avmm_csr_read,
  output logic               avmm_csr_write,
  output logic [31:0]        avmm_csr_writedata,
  input  logic [31:0]        avmm_csr_readdata,
  output logic               timeout_flag
);

  typedef enum logic [3:0] {
    StIdle, StDrdReq, StDrdWait, StDwrReq, StCsrRd, StCsrWait,
    StCsrWr, StPollRd, StPollWait, StAck, StRelease
  } state_e;

  state_e               state_q;
  logic [TIMEOUT_W-1:0] timer_q;
  logic                 cap_read_q;
  logic                 cap_status_q;

  logic        is_data, is_status, is_control;
  logic [31:0] merged_data;
  logic        unused_addr_lsb;

  assign is_data    = (ext_address[23:19] == 5'd0);
  assign is_status  = (ext_address[23:2] == 22'h02_0000);
  assign is_control = (ext_address[23:2] == 22'h02_0001);
  assign unused_addr_lsb = ^ext_address[1:0];

  // Disabled byte lanes are written as erased flash (all ones) so they stay unprogrammed.
  always_comb begin
    merged_data = '1;
    for (int i = 0; i < 4; i++) begin
      if (ext_byte_enable[i]) merged_data[8*i +: 8] = ext_write_data[8*i +: 8];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q             <= StIdle;
      timer_q             <= '0;
      cap_read_q          <= 1'b0;
      cap_status_q        <= 1'b0;
      ext_read_data       <= '0;
      ext_acknowledge     <= 1'b0;
      avmm_data_addr      <= '0;
      avmm_data_read      <= 1'b0;
      avmm_data_write     <= 1'b0;
      avmm_data_writedata <= '0;
      avmm_csr_addr       <= 1'b0;
      avmm_csr_read       <= 1'b0;
      avmm_csr_write      <= 1'b0;
      avmm_csr_writedata  <= '0;
      timeout_flag        <= 1'b0;
    end else begin
      ext_acknowledge <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ext_write || ext_read) begin
            cap_read_q   <= !ext_write;
            cap_status_q <= is_status;
            if (is_data) begin
              avmm_data_addr <= ext_address[DATA_AW+1:2];
              if (ext_write) begin
                avmm_data_writedata <= merged_data;
                avmm_data_write     <= 1'b1;
                state_q             <= StDwrReq;
              end else begin
                avmm_data_read <= 1'b1;
                state_q        <= StDrdReq;
              end
            end else if (is_status || is_control) begin
              if (ext_write) begin
                avmm_csr_addr      <= 1'b1;
                avmm_csr_writedata <= ext_write_data;
                avmm_csr_write     <= 1'b1;
                state_q            <= StCsrWr;
              end else begin
                avmm_csr_addr <= is_control;
                avmm_csr_read <= 1'b1;
                state_q       <= StCsrRd;
              end
            end else begin
              if (!ext_write) ext_read_data <= '0;
              ext_acknowledge <= 1'b1;
              state_q         <= StAck;
            end
          end
        end
        StDrdReq: begin
          if (!avmm_data_waitrequest) begin
            avmm_data_read <= 1'b0;
            if (avmm_data_readdatavalid) begin
              ext_read_data   <= avmm_data_readdata;
              ext_acknowledge <= 1'b1;
              state_q         <= StAck;
            end else begin
              state_q <= StDrdWait;
            end
          end
        end
        StDrdWait: begin
          if (avmm_data_readdatavalid) begin
            ext_read_data   <= avmm_data_readdata;
            ext_acknowledge <= 1'b1;
            state_q         <= StAck;
          end
        end
        StDwrReq: begin
          if (!avmm_data_waitrequest) begin
            avmm_data_write <= 1'b0;
            timer_q         <= '0;
            avmm_csr_addr   <= 1'b0;
            avmm_csr_read   <= 1'b1;
            state_q         <= StPollRd;
          end
        end
        StCsrRd: begin
          avmm_csr_read <= 1'b0;
          state_q       <= StCsrWait;
        end
        StCsrWait: begin
          ext_read_data   <= cap_status_q ? {timeout_flag, avmm_csr_readdata[30:0]}
                                          : avmm_csr_readdata;
          ext_acknowledge <= 1'b1;
          state_q         <= StAck;
        end
        StCsrWr: begin
          avmm_csr_write <= 1'b0;
          timer_q        <= '0;
          avmm_csr_addr  <= 1'b0;
          avmm_csr_read  <= 1'b1;
          state_q        <= StPollRd;
        end
        StPollRd: begin
          avmm_csr_read <= 1'b0;
          if (timer_q != '1) timer_q <= timer_q + 1'b1;
          state_q <= StPollWait;
        end
        StPollWait: begin
          if (timer_q != '1) timer_q <= timer_q + 1'b1;
          if (avmm_csr_readdata[1:0] == 2'b00) begin
            ext_acknowledge <= 1'b1;
            state_q         <= StAck;
          end else if (timer_q < TIMEOUT_CYCLES) begin
            avmm_csr_read <= 1'b1;
            state_q       <= StPollRd;
          end else begin
            timeout_flag    <= 1'b1;
            ext_acknowledge <= 1'b1;
            state_q         <= StAck;
          end
        end
        StAck: begin
          // Timeouts are only raised in StPollWait, so clearing here cannot mask a new one.
          if (cap_read_q && cap_status_q) timeout_flag <= 1'b0;
          state_q <= StRelease;
        end
        StRelease: begin
          if (!ext_read && !ext_write) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ufm_ext_responder.sv
// Self-checking bench for ufm_ext_responder: a reactive UFM model on the Avalon ports and a
// queue of expected read data popped when each acknowledge arrives.
module tb_ufm_ext_responder;

  localparam int unsigned AW = 17;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [23:0]   ext_address;
  logic          ext_read, ext_write;
  logic [31:0]   ext_write_data;
  logic [3:0]    ext_byte_enable;
  logic [31:0]   ext_read_data;
  logic          ext_acknowledge;
  logic [AW-1:0] avmm_data_addr;
  logic          avmm_data_read, avmm_data_write;
  logic [31:0]   avmm_data_writedata, avmm_data_readdata;
  logic          avmm_data_waitrequest, avmm_data_readdatavalid;
  logic          avmm_csr_addr, avmm_csr_read, avmm_csr_write;
  logic [31:0]   avmm_csr_writedata, avmm_csr_readdata;
  logic          timeout_flag;

  ufm_ext_responder #(
    .DATA_AW       (AW),
    .TIMEOUT_W     (24),
    .TIMEOUT_CYCLES(24'd20)
  ) dut (
    .CLK                    (CLK),
    .nRST                   (nRST),
    .ext_address            (ext_address),
    .ext_read               (ext_read),
    .ext_write              (ext_write),
    .ext_write_data         (ext_write_data),
    .ext_byte_enable        (ext_byte_enable),
    .ext_read_data          (ext_read_data),
    .ext_acknowledge        (ext_acknowledge),
    .avmm_data_addr         (avmm_data_addr),
    .avmm_data_read         (avmm_data_read),
    .avmm_data_write        (avmm_data_write),
    .avmm_data_writedata    (avmm_data_writedata),
    .avmm_data_readdata     (avmm_data_readdata),
    .avmm_data_waitrequest  (avmm_data_waitrequest),
    .avmm_data_readdatavalid(avmm_data_readdatavalid),
    .avmm_csr_addr          (avmm_csr_addr),
    .avmm_csr_read          (avmm_csr_read),
    .avmm_csr_write         (avmm_csr_write),
    .avmm_csr_writedata     (avmm_csr_writedata),
    .avmm_csr_readdata      (avmm_csr_readdata),
    .timeout_flag           (timeout_flag)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] last_rdata = 32'h0;
  logic [31:0] status_base = 32'hF000_00A0;

  // UFM model configuration and observation counters
  int            cfg_wait = 0;
  bit            cfg_rv_hold = 0;
  logic [31:0]   cfg_rdata = 32'h0;
  int            busy_left = 0;
  bit            stuck = 0;
  logic [1:0]    stuck_val = 2'b00;
  int            data_rd_acc = 0, data_wr_acc = 0, csr_rd_cnt = 0, csr_wr_cnt = 0;
  int            strobe_cycles = 0, multi_strobe = 0;
  logic [AW-1:0] last_data_addr = '0;
  logic [31:0]   last_data_wdata = '0, last_csr_wdata = '0;
  logic          last_csr_waddr = 1'b0;

  initial begin
    int wait_left;
    bit in_acc;
    bit rv_pend;
    int strobes;
    wait_left = 0; in_acc = 0; rv_pend = 0;
    avmm_data_readdata = '0; avmm_data_waitrequest = 0; avmm_data_readdatavalid = 0;
    avmm_csr_readdata = '0;
    forever begin
      @(negedge CLK);
      avmm_data_readdatavalid = 1'b0;
      if (!nRST) begin
        in_acc = 0; rv_pend = 0; avmm_data_waitrequest = 1'b0;
      end else begin
        strobes = int'(avmm_data_read) + int'(avmm_data_write) + int'(avmm_csr_read)
                + int'(avmm_csr_write);
        if (strobes != 0) strobe_cycles++;
        if (strobes > 1) multi_strobe++;
        if (rv_pend && !cfg_rv_hold) begin
          avmm_data_readdatavalid = 1'b1;
          avmm_data_readdata = cfg_rdata;
          rv_pend = 0;
        end
        if (avmm_data_read || avmm_data_write) begin
          if (!in_acc) begin in_acc = 1; wait_left = cfg_wait; end
          if (wait_left > 0) begin
            avmm_data_waitrequest = 1'b1;
            wait_left--;
          end else begin
            avmm_data_waitrequest = 1'b0;
            in_acc = 0;
            last_data_addr = avmm_data_addr;
            if (avmm_data_read) begin
              data_rd_acc++;
              rv_pend = 1;
            end else begin
              data_wr_acc++;
              last_data_wdata = avmm_data_writedata;
            end
          end
        end else begin
          avmm_data_waitrequest = 1'b0;
        end
        if (avmm_csr_read) begin
          csr_rd_cnt++;
          if (avmm_csr_addr == 1'b0) begin
            if (stuck) avmm_csr_readdata = {status_base[31:2], stuck_val};
            else if (busy_left > 0) begin
              busy_left--;
              avmm_csr_readdata = {status_base[31:2], 2'b10};
            end else avmm_csr_readdata = status_base;
          end else begin
            avmm_csr_readdata = 32'h0;
          end
        end
        if (avmm_csr_write) begin
          csr_wr_cnt++;
          last_csr_waddr = avmm_csr_addr;
          last_csr_wdata = avmm_csr_writedata;
        end
      end
    end
  end

  // Drives one held request, waits (bounded) for ack, holds 3 more cycles, then releases.
  task automatic do_req(input bit wr, input logic [23:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output int cyc, output bit got,
                        output logic [31:0] rd, output int extra);
    @(negedge CLK);
    ext_address = addr; ext_write_data = wdata; ext_byte_enable = be;
    ext_write = wr; ext_read = !wr;
    got = 0; cyc = 0; rd = '0; extra = 0;
    while (!got && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      if (ext_acknowledge) begin got = 1; rd = ext_read_data; end
    end
    repeat (3) begin
      @(negedge CLK);
      if (ext_acknowledge) extra++;
    end
    ext_read = 1'b0; ext_write = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ext_acknowledge, avmm_data_read, avmm_data_write, avmm_csr_read, avmm_csr_write,
         avmm_csr_addr, timeout_flag} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0", {ext_acknowledge, avmm_data_read,
               avmm_data_write, avmm_csr_read, avmm_csr_write, avmm_csr_addr, timeout_flag});
    end
    checks++;
    if ({ext_read_data, avmm_data_addr, avmm_data_writedata, avmm_csr_writedata} !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h %h %h %h expected 0", ext_read_data, avmm_data_addr,
               avmm_data_writedata, avmm_csr_writedata);
    end
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_data_read();
    int cyc, extra, r0;
    bit got;
    logic [31:0] rd, exp;
    cfg_wait = 2; cfg_rdata = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    r0 = data_rd_acc;
    do_req(1'b0, 24'h00_0010, 32'h0, 4'hF, cyc, got, rd, extra);
    exp = exp_q.pop_front();
    last_rdata = exp;
    checks++;
    if (!got) begin failures++; $display("FAIL rd_ack: no ack within %0d cycles", cyc); end
    checks++;
    if (rd !== exp) begin failures++; $display("FAIL rd_data: got %h expected %h", rd, exp); end
    checks++;
    if (last_data_addr !== 17'd4) begin
      failures++; $display("FAIL rd_addr: got %h expected 4", last_data_addr);
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL rd_extra_ack: got %0d expected 0", extra); end
    checks++;
    if (data_rd_acc - r0 != 1) begin
      failures++; $display("FAIL rd_access_count: got %0d expected 1", data_rd_acc - r0);
    end
  endtask

  task automatic test_data_write();
    int cyc, extra, p0, w0;
    bit got;
    logic [31:0] rd;
    cfg_wait = 1; busy_left = 2;
    p0 = csr_rd_cnt; w0 = data_wr_acc;
    do_req(1'b1, 24'h00_0020, 32'h1234_5678, 4'b0011, cyc, got, rd, extra);
    checks++;
    if (!got) begin failures++; $display("FAIL wr_ack: no ack within %0d cycles", cyc); end
    checks++;
    if (last_data_wdata !== 32'hFFFF_5678) begin
      failures++; $display("FAIL wr_data: got %h expected ffff5678", last_data_wdata);
    end
    checks++;
    if (last_data_addr !== 17'd8) begin
      failures++; $display("FAIL wr_addr: got %h expected 8", last_data_addr);
    end
    checks++;
    if (csr_rd_cnt - p0 != 3 || data_wr_acc - w0 != 1) begin
      failures++; $display("FAIL wr_polls: got polls=%0d writes=%0d expected 3 and 1",
                           csr_rd_cnt - p0, data_wr_acc - w0);
    end
    checks++;
    if (rd !== last_rdata) begin
      failures++; $display("FAIL wr_rdata_held: got %h expected %h", rd, last_rdata);
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL wr_extra_ack: got %0d expected 0", extra); end
  endtask

  task automatic test_erase();
    int cyc, extra, p0, w0;
    bit got;
    logic [31:0] rd;
    busy_left = 1;
    p0 = csr_rd_cnt; w0 = csr_wr_cnt;
    do_req(1'b1, 24'h08_0004, 32'h0010_0000, 4'hF, cyc, got, rd, extra);
    checks++;
    if (!got) begin failures++; $display("FAIL erase_ack: no ack within %0d cycles", cyc); end
    checks++;
    if (last_csr_waddr !== 1'b1 || last_csr_wdata !== 32'h0010_0000) begin
      failures++; $display("FAIL erase_csr: got addr=%b data=%h expected 1 00100000",
                           last_csr_waddr, last_csr_wdata);
    end
    checks++;
    if (csr_wr_cnt - w0 != 1 || csr_rd_cnt - p0 != 2) begin
      failures++; $display("FAIL erase_counts: got writes=%0d polls=%0d expected 1 and 2",
                           csr_wr_cnt - w0, csr_rd_cnt - p0);
    end
  endtask

  task automatic test_unmapped();
    int cyc, extra, s0;
    bit got;
    logic [31:0] rd, exp;
    s0 = strobe_cycles;
    exp_q.push_back(32'h0);
    do_req(1'b0, 24'h0A_0000, 32'h0, 4'hF, cyc, got, rd, extra);
    exp = exp_q.pop_front();
    last_rdata = exp;
    checks++;
    if (!got || cyc > 2) begin
      failures++; $display("FAIL unmapped_rd_ack: got ack=%0b after %0d cycles expected <=2",
                           got, cyc);
    end
    checks++;
    if (rd !== exp) begin failures++; $display("FAIL unmapped_rd_data: got %h expected %h", rd, exp); end
    checks++;
    if (strobe_cycles != s0) begin
      failures++; $display("FAIL unmapped_rd_strobes: got %0d expected 0", strobe_cycles - s0);
    end
    do_req(1'b1, 24'h10_0000, 32'h5555_AAAA, 4'hF, cyc, got, rd, extra);
    checks++;
    if (!got || cyc > 2 || strobe_cycles != s0) begin
      failures++; $display("FAIL unmapped_wr: got ack=%0b cycles=%0d strobes=%0d expected 1 <=2 0",
                           got, cyc, strobe_cycles - s0);
    end
    checks++;
    if (rd !== last_rdata) begin
      failures++; $display("FAIL unmapped_wr_rdata: got %h expected %h", rd, last_rdata);
    end
  endtask

  task automatic test_timeout();
    int cyc, extra, p0;
    bit got;
    logic [31:0] rd, exp;
    stuck = 1; stuck_val = 2'b01; cfg_wait = 0;
    p0 = csr_rd_cnt;
    do_req(1'b1, 24'h00_0040, 32'hA5A5_A5A5, 4'hF, cyc, got, rd, extra);
    stuck = 0;
    checks++;
    if (!got) begin failures++; $display("FAIL to_ack: no ack within %0d cycles", cyc); end
    checks++;
    if (timeout_flag !== 1'b1) begin
      failures++; $display("FAIL to_flag_set: got %b expected 1", timeout_flag);
    end
    checks++;
    if (csr_rd_cnt - p0 < 10 || csr_rd_cnt - p0 > 12) begin
      failures++; $display("FAIL to_polls: got %0d expected 10..12", csr_rd_cnt - p0);
    end
    exp_q.push_back({1'b1, status_base[30:0]});
    do_req(1'b0, 24'h08_0000, 32'h0, 4'hF, cyc, got, rd, extra);
    exp = exp_q.pop_front();
    checks++;
    if (!got || rd !== exp) begin
      failures++; $display("FAIL status_rd1: got ack=%0b data=%h expected %h", got, rd, exp);
    end
    checks++;
    if (timeout_flag !== 1'b0) begin
      failures++; $display("FAIL to_flag_clear: got %b expected 0", timeout_flag);
    end
    exp_q.push_back({1'b0, status_base[30:0]});
    do_req(1'b0, 24'h08_0002, 32'h0, 4'hF, cyc, got, rd, extra);
    exp = exp_q.pop_front();
    last_rdata = exp;
    checks++;
    if (!got || rd !== exp) begin
      failures++; $display("FAIL status_rd2: got ack=%0b data=%h expected %h", got, rd, exp);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, extra, acks;
    bit got;
    logic [31:0] rd, exp;
    cfg_rv_hold = 1; cfg_wait = 0;
    @(negedge CLK);
    ext_address = 24'h00_0100; ext_read = 1'b1; ext_write = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b0;
    #1;
    checks++;
    if ({ext_acknowledge, avmm_data_read, avmm_data_write, avmm_csr_read, avmm_csr_write,
         timeout_flag} !== 6'b0) begin
      failures++; $display("FAIL midrst_ctrl: outputs not cleared");
    end
    checks++;
    if (ext_read_data !== 32'h0 || avmm_data_addr !== '0) begin
      failures++; $display("FAIL midrst_data: got %h %h expected 0", ext_read_data, avmm_data_addr);
    end
    acks = 0;
    repeat (2) begin
      @(negedge CLK);
      if (ext_acknowledge) acks++;
    end
    ext_read = 1'b0; cfg_rv_hold = 0; nRST = 1'b1;
    checks++;
    if (acks != 0) begin failures++; $display("FAIL midrst_ack: got %0d expected 0", acks); end
    cfg_rdata = 32'hCAFE_F00D;
    exp_q.push_back(32'hCAFE_F00D);
    do_req(1'b0, 24'h00_0104, 32'h0, 4'hF, cyc, got, rd, extra);
    exp = exp_q.pop_front();
    checks++;
    if (!got || rd !== exp || last_data_addr !== 17'h41) begin
      failures++; $display("FAIL post_rst_rd: got ack=%0b data=%h addr=%h expected %h 41",
                           got, rd, last_data_addr, exp);
    end
  endtask

  initial begin
    nRST = 1'b0;
    ext_address = '0; ext_read = 1'b0; ext_write = 1'b0;
    ext_write_data = '0; ext_byte_enable = '0;
    test_reset();
    test_data_read();
    test_data_write();
    test_erase();
    test_unmapped();
    test_timeout();
    test_reset_mid();
    checks++;
    if (multi_strobe != 0) begin
      failures++; $display("FAIL single_strobe: got %0d overlapping cycles expected 0", multi_strobe);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
